// File: rtl/crypto_mode_ctrl.sv
// crypto_mode_ctrl: runs ECB/CBC/CTR jobs of N blocks through one block-cipher engine
// and queues the results in a small output FIFO with ready/valid backpressure.
module crypto_mode_ctrl #(
  parameter int BLK_W       = 128,
  parameter int LEN_W       = 16,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [1:0]       cfg_mode_i,
  input  logic             cfg_algo_i,
  input  logic [BLK_W-1:0] cfg_key_i,
  input  logic [BLK_W-1:0] cfg_iv_i,
  input  logic [LEN_W-1:0] cfg_nblk_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [BLK_W-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [BLK_W-1:0] m_data_o,
  output logic             m_last_o,
  output logic             core_start_o,
  output logic             core_algo_sel_o,
  output logic [BLK_W-1:0] core_key_o,
  output logic [BLK_W-1:0] core_din_o,
  input  logic             core_done_i,
  input  logic             core_busy_i,
  input  logic [BLK_W-1:0] core_dout_i,
  output logic             busy_o,
  output logic             err_o
);
  localparam int AW = $clog2(OFIFO_DEPTH);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_KICK  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [1:0]       mode_q;
  logic             algo_q, err_q;
  logic [BLK_W-1:0] key_q, chain_q, ctr_q, pt_q, din_q, ct_q, din_d, ct_d;
  logic [LEN_W-1:0] rem_q;
  logic [BLK_W:0]   mem_q [OFIFO_DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             cfg_ok, hs, last, push, pop, full;

  assign cfg_ready_o     = state_q == S_IDLE;
  assign busy_o          = state_q != S_IDLE;
  assign err_o           = err_q;
  assign core_start_o    = state_q == S_KICK;
  assign core_algo_sel_o = algo_q;
  assign core_key_o      = key_q;
  assign core_din_o      = din_q;
  assign m_valid_o       = cnt_q != '0;
  assign m_data_o        = m_valid_o ? mem_q[rp_q][BLK_W:1] : '0;
  assign m_last_o        = m_valid_o && mem_q[rp_q][0];
  // a free FIFO slot is reserved before fetching, so STORE can never overflow
  assign s_ready_o       = state_q == S_FETCH && !full && !core_busy_i;

  always_comb begin
    cfg_ok  = cfg_valid_i && cfg_mode_i != 2'b11 && cfg_nblk_i != '0;
    full    = cnt_q == (AW+1)'(OFIFO_DEPTH);
    hs      = s_valid_i && s_ready_o;
    last    = rem_q == LEN_W'(1);
    push    = state_q == S_STORE;
    pop     = m_valid_o && m_ready_i;
    din_d   = mode_q == M_CTR ? ctr_q : mode_q == M_CBC ? s_data_i ^ chain_q : s_data_i;
    ct_d    = mode_q == M_CTR ? pt_q ^ core_dout_i : core_dout_i;
    state_d = state_q == S_IDLE  ? (cfg_ok ? S_FETCH : S_IDLE) :
              state_q == S_FETCH ? (hs ? S_KICK : S_FETCH) :
              state_q == S_KICK  ? S_WAIT :
              state_q == S_WAIT  ? (core_done_i ? S_STORE : S_WAIT) :
              state_q == S_STORE ? (last ? S_IDLE : S_FETCH) : S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      algo_q  <= 1'b0;
      key_q   <= '0;
      chain_q <= '0;
      ctr_q   <= '0;
      pt_q    <= '0;
      din_q   <= '0;
      ct_q    <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= state_q == S_IDLE && cfg_valid_i && !cfg_ok;
      if (state_q == S_IDLE && cfg_ok) begin
        mode_q  <= cfg_mode_i;
        algo_q  <= cfg_algo_i;
        key_q   <= cfg_key_i;
        chain_q <= cfg_iv_i;
        ctr_q   <= cfg_iv_i;
        rem_q   <= cfg_nblk_i;
      end
      if (hs) begin
        pt_q  <= s_data_i;
        din_q <= din_d;
      end
      if (state_q == S_WAIT && core_done_i) begin
        ct_q <= ct_d;
        if (mode_q == M_CBC) chain_q <= ct_d;
        if (mode_q == M_CTR) ctr_q <= ctr_q + BLK_W'(1);
      end
      if (push) begin
        wp_q  <= wp_q + AW'(1);
        rem_q <= rem_q - LEN_W'(1);
      end
      if (pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i)
    if (push) mem_q[wp_q] <= {ct_q, last};
endmodule

// File: tb/tb_crypto_mode_ctrl.sv
// tb_crypto_mode_ctrl: randomized and directed checks of crypto_mode_ctrl against a
// mode-level reference model, with a behavioural engine that knows the standard vectors.
module tb_crypto_mode_ctrl;
  localparam logic [127:0] K_AES = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] IV    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CTR0  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] K_SM4 = 128'h0123456789abcdeffedcba9876543210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0, cfg_ready, cfg_algo = 1'b0;
  logic [1:0]   cfg_mode = '0;
  logic [127:0] cfg_key = '0, cfg_iv = '0;
  logic [15:0]  cfg_nblk = '0;
  logic         s_valid = 1'b0, s_ready;
  logic [127:0] s_data = '0;
  logic         m_valid, m_ready = 1'b1, m_last;
  logic [127:0] m_data;
  logic         core_start, core_algo_sel;
  logic [127:0] core_key, core_din;
  logic         core_done = 1'b0, core_busy = 1'b0;
  logic [127:0] core_dout = '0;
  logic         busy, err;

  int           total = 0, bad = 0;
  logic [128:0] exp_q[$], got_q[$];
  logic [127:0] pt_a [16];
  int           mr_mode = 0, starts = 0, lat = 0;
  bit           abort = 1'b0, stalled = 1'b0;
  logic [128:0] held = '0;
  logic [127:0] last_din = '0, ekey = '0, edin = '0;
  logic         eb = 1'b0, eabort = 1'b0, ealgo = 1'b0;

  crypto_mode_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_mode_i(cfg_mode),
    .cfg_algo_i(cfg_algo), .cfg_key_i(cfg_key), .cfg_iv_i(cfg_iv), .cfg_nblk_i(cfg_nblk),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .core_start_o(core_start), .core_algo_sel_o(core_algo_sel), .core_key_o(core_key),
    .core_din_o(core_din), .core_done_i(core_done), .core_busy_i(core_busy),
    .core_dout_i(core_dout), .busy_o(busy), .err_o(err)
  );

  // stand-in cipher: published AES/SM4 answers for the known vectors, a keyed mix otherwise
  function automatic logic [127:0] eng(input logic a, input logic [127:0] k, input logic [127:0] d);
    if (!a && k == K_AES) begin
      if (d == P1) return 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      if (d == 128'h6bc0bce12a459991e134741a7f9e1925) return 128'h7649abac8119b246cee98e9b12e9197d;
      if (d == 128'hd86421fb9f1a1eda505ee1375746972c) return 128'h5086cb9b507219ee95db113a917678b2;
      if (d == CTR0) return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    end
    if (a && k == K_SM4 && d == K_SM4) return 128'h681edf34d206965e86b3e94f536e4246;
    return {d[90:0], d[127:91]} ^ k ^ {a, 63'h0, 32'h9e3779b9, 32'h0};
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [259:0] got, input logic [259:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // engine with 1..4 cycle latency; an in-flight block survives controller reset
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (!rst_n) eabort <= 1'b1;
    if (eb) begin
      if (lat == 0) begin
        core_done <= 1'b1;
        core_dout <= eng(ealgo, ekey, edin);
        eb        <= 1'b0;
        core_busy <= 1'b0;
      end else lat <= lat - 1;
    end else if (core_start) begin
      eb       <= 1'b1;
      core_busy <= 1'b1;
      lat      <= $urandom_range(0, 3);
      ekey     <= core_key;
      edin     <= core_din;
      ealgo    <= core_algo_sel;
      eabort   <= !rst_n;
      starts   <= starts + 1;
      last_din <= core_din;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) stalled = 1'b0;
    else begin
      if (stalled && m_valid) chk("m_hold", 260'({m_data, m_last}), 260'(held));
      if (eb && !eabort) chk("core_hold", 260'({core_algo_sel, core_key, core_din}), 260'({ealgo, ekey, edin}));
      m_ready = mr_mode == 0 ? 1'b1 : mr_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        got_q.push_back({m_data, m_last});
        if (exp_q.size() == 0) chk("m_unexpected", 260'(exp_q.size()), 260'(1));
        else chk("m_out", 260'({m_data, m_last}), 260'(exp_q.pop_front()));
      end
      stalled = m_valid && !m_ready;
      held    = {m_data, m_last};
    end
  end

  task automatic model(input logic [1:0] md, input logic al, input logic [127:0] k, input logic [127:0] iv, input int n);
    logic [127:0] chain = iv, ctr = iv, ct;
    for (int i = 0; i < n; i++) begin
      if (md == 2'b00) ct = eng(al, k, pt_a[i]);
      else if (md == 2'b01) begin
        ct    = eng(al, k, pt_a[i] ^ chain);
        chain = ct;
      end else begin
        ct  = pt_a[i] ^ eng(al, k, ctr);
        ctr = ctr + 128'd1;
      end
      exp_q.push_back({ct, i == n - 1});
    end
  endtask

  task automatic send(input logic [127:0] d);
    int w = 0;
    if (abort) return;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && w < 2000 && !abort) begin
      @(negedge clk);
      w++;
    end
    if (!abort) begin
      chk("s_wait", 260'(w < 2000), 260'(1'b1));
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic send_all(input int n);
    for (int i = 0; i < n; i++) send(pt_a[i]);
  endtask

  task automatic run_job(input logic [1:0] md, input logic al, input logic [127:0] k, input logic [127:0] iv, input int n, input bit bg);
    int w = 0;
    bit rej;
    while (!cfg_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("cfg_wait", 260'(w < 2000), 260'(1'b1));
    cfg_valid = 1'b1;
    cfg_mode  = md;
    cfg_algo  = al;
    cfg_key   = k;
    cfg_iv    = iv;
    cfg_nblk  = 16'(n);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    rej = md == 2'b11 || n == 0;
    chk("err", 260'(err), 260'(rej));
    chk("busy", 260'(busy), 260'(!rej));
    if (!rej) begin
      model(md, al, k, iv, n);
      if (bg) fork send_all(n); join_none
      else send_all(n);
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((busy || m_valid || exp_q.size() != 0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 260'(w < 5000), 260'(1'b1));
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_flags"}, 260'({cfg_ready, busy, err, s_ready, m_valid, m_last, core_start, core_algo_sel}), 260'(8'b1000_0000));
    chk({t, "_data"}, 260'({m_data, core_din}), 260'(0));
    chk({t, "_key"}, 260'(core_key), 260'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, seen, w;
    logic [127:0] k, iv;
    logic [1:0] md;
    int r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    @(negedge clk);

    got_q.delete();
    pt_a[0] = P1;
    run_job(2'b00, 1'b0, K_AES, '0, 1, 1'b0);
    drain();
    chk("ecb_vec", 260'(got_q[0]), 260'({128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b1}));
    chk("ecb_idle", 260'({busy, got_q.size()}), 260'({1'b0, 32'd1}));

    got_q.delete();
    pt_a[0] = P1;
    pt_a[1] = P2;
    run_job(2'b01, 1'b0, K_AES, IV, 2, 1'b0);
    drain();
    chk("cbc_vec0", 260'(got_q[0]), 260'({128'h7649abac8119b246cee98e9b12e9197d, 1'b0}));
    chk("cbc_vec1", 260'(got_q[1]), 260'({128'h5086cb9b507219ee95db113a917678b2, 1'b1}));

    got_q.delete();
    pt_a[0] = P1;
    run_job(2'b10, 1'b0, K_AES, CTR0, 1, 1'b0);
    drain();
    chk("ctr_vec", 260'(got_q[0]), 260'({128'h874d6191b620e3261bef6864990db6ce, 1'b1}));

    pt_a[0] = rnd();
    pt_a[1] = rnd();
    run_job(2'b10, 1'b0, K_AES, '1, 2, 1'b0);
    drain();
    chk("ctr_wrap_din", 260'(last_din), 260'(0));

    got_q.delete();
    pt_a[0] = K_SM4;
    run_job(2'b00, 1'b1, K_SM4, '0, 1, 1'b0);
    chk("algo_sm4", 260'(core_algo_sel), 260'(1'b1));
    pt_a[0] = P1;
    run_job(2'b00, 1'b0, K_AES, '0, 1, 1'b0);
    chk("algo_aes", 260'(core_algo_sel), 260'(1'b0));
    drain();
    chk("sm4_vec", 260'(got_q[0]), 260'({128'h681edf34d206965e86b3e94f536e4246, 1'b1}));
    chk("aes_after_sm4", 260'(got_q[1]), 260'({128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b1}));

    @(posedge clk);
    mr_mode = 2;
    @(negedge clk);
    got_q.delete();
    for (int i = 0; i < 6; i++) pt_a[i] = rnd();
    s0 = starts;
    run_job(2'b00, 1'b0, rnd(), '0, 6, 1'b1);
    repeat (80) @(negedge clk);
    chk("bp_blocks", 260'(starts - s0), 260'(4));
    chk("bp_s_ready", 260'(s_ready), 260'(1'b0));
    chk("bp_m_valid", 260'(m_valid), 260'(1'b1));
    @(posedge clk);
    mr_mode = 0;
    @(negedge clk);
    drain();
    chk("bp_count", 260'(got_q.size()), 260'(6));

    s0 = starts;
    run_job(2'b11, 1'b0, K_AES, IV, 3, 1'b0);
    @(negedge clk);
    chk("mode11_pulse", 260'({err, cfg_ready}), 260'(2'b01));
    run_job(2'b00, 1'b0, K_AES, IV, 0, 1'b0);
    @(negedge clk);
    chk("nblk0_pulse", 260'({err, cfg_ready}), 260'(2'b01));
    repeat (5) @(negedge clk);
    chk("err_no_start", 260'(starts - s0), 260'(0));

    for (int i = 0; i < 4; i++) pt_a[i] = rnd();
    k  = rnd();
    iv = rnd();
    run_job(2'b01, 1'b0, k, iv, 4, 1'b1);
    seen = 0;
    w    = 0;
    while (seen < 2 && w < 500) begin
      @(negedge clk);
      if (core_start) seen++;
      w++;
    end
    chk("rst_reach_blk2", 260'(seen), 260'(2));
    @(negedge clk);
    abort   = 1'b1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_rst("midrst");
    exp_q.delete();
    got_q.delete();
    rst_n = 1'b1;
    abort = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) pt_a[i] = rnd();
    run_job(2'b00, 1'b0, k, '0, 3, 1'b0);
    drain();
    chk("post_rst_count", 260'(got_q.size()), 260'(3));

    @(posedge clk);
    mr_mode = 1;
    @(negedge clk);
    for (int j = 0; j < 30; j++) begin
      r  = $urandom_range(0, 9);
      md = r == 9 ? 2'b11 : 2'(r % 3);
      iv = $urandom_range(0, 3) == 0 ? '1 - 128'($urandom_range(0, 2)) : rnd();
      for (int i = 0; i < 6; i++) pt_a[i] = rnd();
      run_job(md, 1'($urandom_range(0, 1)), rnd(), iv, $urandom_range(0, 5), 1'b0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/crypto_mode_ctrl.md
# crypto_mode_ctrl

Multi-block mode controller that sits between the DMA/stream fabric and one `crypto_engine` instance (AES-128 / SM4). It runs a job of N 128-bit blocks in ECB, CBC or CTR mode, sequences the engine's start/done handshake once per block, applies the chaining or counter logic, and buffers results in an output FIFO with ready/valid backpressure. It extends single-block engine use with per-job key/IV configuration, block counting, counter wrap, and error reporting.

## Interface
- `BLK_W`, 128: block/key/IV width; fixed at 128 by the engine.
- `LEN_W`, 16: width of the job block-count field.
- `OFIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_valid`/`cfg_ready` in/out 1: job-config handshake; `cfg_ready`=1 only in IDLE.
- `cfg_mode` in 2: 00 ECB, 01 CBC, 10 CTR, 11 reserved.
- `cfg_algo` in 1: 0 AES, 1 SM4; forwarded as `core_algo_sel`.
- `cfg_key`, `cfg_iv` in BLK_W: key; IV (CBC) or initial counter (CTR).
- `cfg_nblk` in LEN_W: number of blocks in the job.
- `s_valid`/`s_ready` in/out 1, `s_data` in BLK_W: plaintext stream.
- `m_valid`/`m_ready` out/in 1, `m_data` out BLK_W, `m_last` out 1: ciphertext stream; `m_last` marks the job's final block.
- `core_start` out 1, `core_algo_sel` out 1, `core_key` out BLK_W, `core_din` out BLK_W: engine drive.
- `core_done` in 1, `core_busy` in 1, `core_dout` in BLK_W: engine response.
- `busy` out 1: job in progress (any state except IDLE).
- `err` out 1: one-cycle pulse on a rejected config.

## Operation
- FSM states: IDLE, FETCH, KICK, WAIT, STORE.
- IDLE: on `cfg_valid`, latch mode/algo/key/IV/nblk. If mode=11 or nblk=0, pulse `err` and stay in IDLE; no engine activity, no output. Otherwise go to FETCH, with `chain`←IV, `ctr`←IV, and `remaining`←nblk.
- FETCH: `s_ready`=1 only when the FIFO has ≥1 free entry and `core_busy`=0. On an `s_valid` & `s_ready` handshake, latch `pt`, form `core_din`, then go to KICK.
  - ECB: `core_din` = pt.
  - CBC: `core_din` = pt ^ chain.
  - CTR: `core_din` = ctr.
- KICK: `core_start`=1 for exactly one cycle, then go to WAIT. `core_din`, `core_key` and `core_algo_sel` stay stable from KICK until `core_done`.
- WAIT: on `core_done`, compute the result and go to STORE.
  - ECB and CBC: ct = core_dout. CBC also sets chain←ct.
  - CTR: ct = pt ^ core_dout, then ctr←ctr+1 mod 2^128. All-ones wraps to zero with no flag.
- STORE: push {ct, last=(remaining==1)} into the FIFO and decrement `remaining`. If `remaining` was 1, go to IDLE; else go to FETCH.
- The FIFO drains independently of the FSM. `m_valid` = FIFO not empty. Pop on `m_valid`&`m_ready`. A simultaneous push and pop is allowed and leaves the count unchanged.
- Because FETCH requires a free entry, the FIFO never overflows. Entries still queued after the FSM returns to IDLE keep draining, and a new job may be configured while they drain.
- Config inputs are ignored outside IDLE. `s_data` is ignored outside FETCH.

## Timing
- Reset values (all outputs):
  - `cfg_ready`=1.
  - `busy`=0, `err`=0.
  - `s_ready`=0, `m_valid`=0, `m_last`=0, `m_data`=0.
  - `core_start`=0, `core_din`=0, `core_key`=0, `core_algo_sel`=0.
  - FIFO empty, FSM in IDLE.
- Reset asserted mid-job (sampled on clk) aborts the job and flushes the FIFO. Any in-flight `core_done` after reset is ignored because the FSM is in IDLE.
- Config accept → `busy`=1 the next cycle. `err` pulses the cycle after the rejected `cfg_valid`.
- Input handshake at edge t → `core_start` high in cycle t+1.
- `core_done` sampled at edge t → FIFO write at t+1 → `m_valid` high from cycle t+2 if the FIFO was empty.
- Per-block overhead beyond engine latency: 3 cycles.
- `busy` falls the cycle after the final STORE.
- `m_data`/`m_last` are held stable while `m_valid`=1 and `m_ready`=0.

## Test plan
- AES ECB, key 2b7e151628aed2a6abf7158809cf4f3c, nblk=1, pt 6bc1bee22e409f96e93d7e117393172a → m_data 3ad77bb40d7a3660a89ecaf32466ef97, m_last=1, busy falls after.
- AES CBC, same key, IV 000102030405060708090a0b0c0d0e0f, 2 blocks: pt 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 → 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2; m_last only on the second.
- AES CTR, same key, counter f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, pt 6bc1bee22e409f96e93d7e117393172a → 874d6191b620e3261bef6864990db6ce. Separate run with counter all-ones, nblk=2: second block's core_din = 0.
- SM4 ECB, key and pt 0123456789abcdeffedcba9876543210 → 681edf34d206965e86b3e94f536e4246. Then an immediate AES job confirms core_algo_sel switches.
- Backpressure: ECB, nblk=6, m_ready=0 → exactly OFIFO_DEPTH blocks processed, s_ready held 0. Release m_ready → all 6 outputs in order, m_data stable while stalled.
- Errors and reset:
  - mode=11 → err pulse, no core_start, cfg_ready stays 1.
  - nblk=0 → err pulse, no core_start, cfg_ready stays 1.
  - rst_n low during WAIT of block 2 of 4 → all outputs return to reset values, FIFO empty, and the next job runs correctly.
